// File: rtl/debounce_array.sv
// debounce_array: per-channel synchroniser + counter debouncer with
// edge pulses, optional toggle mode and sticky write-1-to-clear event flags.
module debounce_array #(
    parameter int unsigned CHANNELS      = 16,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 500000,
    parameter int unsigned CNT_W         = 20
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] raw,
    input  logic [CHANNELS-1:0] toggle_en,
    input  logic                toggle_clr,
    input  logic [CHANNELS-1:0] event_ack,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] toggle,
    output logic [CHANNELS-1:0] event_flags,
    output logic                event_any
);

    // Terminal count: the mismatch that finds cnt here is the committing one.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] sync_pipe [SYNC_STAGES];
    logic [CHANNELS-1:0] sync;
    logic [CNT_W-1:0]    cnt [CHANNELS];
    logic [CHANNELS-1:0] mismatch;
    logic [CHANNELS-1:0] commit;
    logic [CHANNELS-1:0] rise_nxt;
    logic [CHANNELS-1:0] fall_nxt;

    assign sync = sync_pipe[SYNC_STAGES-1];

    // Multi-stage synchroniser for all raw inputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_pipe[s] <= '0;
            end
        end else begin
            sync_pipe[0] <= raw;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_pipe[s] <= sync_pipe[s-1];
            end
        end
    end

    // Detect channels whose mismatch has lasted long enough to commit.
    always_comb begin
        mismatch = sync ^ level;
        commit   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            commit[i] = mismatch[i] && (cnt[i] == CNT_LAST);
        end
        rise_nxt = commit & sync;
        fall_nxt = commit & ~sync;
    end

    // Per-channel stability counters; restart on agreement or on commit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (!mismatch[i] || commit[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounced level and single-cycle edge pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
            rise  <= '0;
            fall  <= '0;
        end else begin
            level <= level ^ commit;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // Toggle state flips on enabled rises; a clear overrides a same-cycle rise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            toggle <= '0;
        end else if (toggle_clr) begin
            toggle <= '0;
        end else begin
            toggle <= toggle ^ (rise_nxt & toggle_en);
        end
    end

    // Sticky event flags; a commit in the same cycle as an ack keeps the flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            event_flags <= '0;
            event_any   <= 1'b0;
        end else begin
            event_flags <= (event_flags & ~event_ack) | commit;
            event_any   <= |event_flags;
        end
    end

endmodule

// File: tb/tb_debounce_array.sv
// Directed self-checking bench for debounce_array (4 channels, 8-cycle debounce).
module tb_debounce_array;

    logic       clock;
    logic       reset_n;
    logic [3:0] raw;
    logic [3:0] toggle_en;
    logic       toggle_clr;
    logic [3:0] event_ack;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] toggle;
    logic [3:0] event_flags;
    logic       event_any;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_tog;

    debounce_array #(
        .CHANNELS      (4),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8),
        .CNT_W         (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .raw         (raw),
        .toggle_en   (toggle_en),
        .toggle_clr  (toggle_clr),
        .event_ack   (event_ack),
        .level       (level),
        .rise        (rise),
        .fall        (fall),
        .toggle      (toggle),
        .event_flags (event_flags),
        .event_any   (event_any)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n    = 1'b1;
        raw        = 4'b1111;
        toggle_en  = 4'b0000;
        toggle_clr = 1'b0;
        event_ack  = 4'b0000;

        // Reset asserted with raw high
        #2 reset_n = 1'b0;
        #1;
        chk("reset_async", {level, rise, fall, toggle, event_flags, event_any}, 0);
        tick(3);
        chk("reset_held", {level, rise, fall, toggle, event_flags, event_any}, 0);

        // Power-on step: commit on the 10th edge after release
        reset_n = 1'b1;
        tick(9);
        chk("por_level_e9", level, 4'b0000);
        chk("por_rise_e9", rise, 4'b0000);
        tick(1);
        chk("por_level_e10", level, 4'b1111);
        chk("por_rise_e10", rise, 4'b1111);
        chk("por_fall_e10", fall, 4'b0000);
        chk("por_flags_e10", event_flags, 4'b1111);
        chk("por_any_e10", event_any, 1'b0);
        tick(1);
        chk("por_rise_e11", rise, 4'b0000);
        chk("por_level_e11", level, 4'b1111);
        chk("por_any_e11", event_any, 1'b1);
        chk("por_toggle", toggle, 4'b0000);
        event_ack = 4'b1111;
        tick(1);
        event_ack = 4'b0000;
        chk("ack_all_flags", event_flags, 4'b0000);
        tick(1);
        chk("ack_all_any", event_any, 1'b0);

        // Channel 0: fall, then bounce, then a clean hold at 1
        raw[0] = 1'b0;
        tick(9);
        chk("ch0_fall_pre", level, 4'b1111);
        tick(1);
        chk("ch0_fall", fall, 4'b0001);
        chk("ch0_fall_level", level, 4'b1110);
        for (int seg = 0; seg < 10; seg++) begin
            raw[0] = (seg % 2 == 0) ? 1'b1 : 1'b0;
            for (int c = 0; c < 3; c++) begin
                tick(1);
                chk("bounce_quiet", {rise[0], fall[0], level[0]}, 3'b000);
            end
        end
        raw[0] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            chk("bounce_settle", {rise[0], level[0]}, 2'b00);
        end
        tick(1);
        chk("bounce_rise", rise, 4'b0001);
        chk("bounce_level", level[0], 1'b1);
        chk("bounce_no_toggle", toggle, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("bounce_single_pulse", rise, 4'b0000);
        end

        // Channel 1: glitch threshold
        raw[1] = 1'b0;
        tick(10);
        chk("ch1_fall", fall, 4'b0010);
        chk("ch1_fall_level", level, 4'b1101);
        raw[1] = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick(1);
            if (i == 7) raw[1] = 1'b0;
            chk("glitch7_quiet", {rise[1], level[1]}, 2'b00);
        end
        raw[1] = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick(1);
            if (i == 8) raw[1] = 1'b0;
            chk("glitch8_pre", level[1], 1'b0);
        end
        tick(1);
        chk("glitch8_rise", rise, 4'b0010);
        chk("glitch8_level", level[1], 1'b1);
        tick(7);
        chk("glitch8_hold", {fall[1], level[1]}, 2'b01);
        tick(1);
        chk("glitch8_fall", fall, 4'b0010);
        chk("glitch8_fall_level", level[1], 1'b0);

        // Channel 2: toggle mode
        toggle_en = 4'b0100;
        exp_tog   = 4'b0000;
        for (int p = 0; p < 3; p++) begin
            raw[2] = 1'b0;
            tick(10);
            chk("tog_fall", fall, 4'b0100);
            chk("tog_after_fall", toggle, exp_tog);
            raw[2] = 1'b1;
            tick(10);
            exp_tog = (p % 2 == 0) ? 4'b0100 : 4'b0000;
            chk("tog_rise", rise, 4'b0100);
            chk("tog_state", toggle, exp_tog);
        end
        raw[2] = 1'b0;
        tick(10);
        chk("tog4_fall_keeps", toggle, 4'b0100);
        raw[2] = 1'b1;
        tick(9);
        toggle_clr = 1'b1;
        tick(1);
        toggle_clr = 1'b0;
        chk("tog4_rise", rise, 4'b0100);
        chk("tog4_clr_wins", toggle, 4'b0000);

        // Channel 3: sticky flags
        raw[3] = 1'b0;
        tick(10);
        chk("ch3_fall", fall, 4'b1000);
        event_ack = 4'b1111;
        tick(1);
        event_ack = 4'b0000;
        tick(1);
        chk("flags_cleared", event_flags, 4'b0000);
        chk("any_cleared", event_any, 1'b0);
        raw[3] = 1'b1;
        tick(10);
        chk("ch3_rise", rise, 4'b1000);
        chk("ch3_flag_set", event_flags, 4'b1000);
        chk("ch3_any_lag", event_any, 1'b0);
        tick(1);
        chk("ch3_any_set", event_any, 1'b1);
        chk("ch3_flag_hold", event_flags, 4'b1000);
        raw[3] = 1'b0;
        tick(9);
        event_ack = 4'b1000;
        tick(1);
        event_ack = 4'b0000;
        chk("ack_vs_commit_fall", fall, 4'b1000);
        chk("ack_vs_commit_flag", event_flags, 4'b1000);
        tick(1);
        chk("ack_vs_commit_after", event_flags, 4'b1000);
        event_ack = 4'b1000;
        tick(1);
        event_ack = 4'b0000;
        chk("lone_ack_flag", event_flags, 4'b0000);
        tick(1);
        chk("lone_ack_any", event_any, 1'b0);

        // Asynchronous reset mid-count on channel 2 (cnt reaches 5)
        raw[2] = 1'b0;
        tick(7);
        chk("pre_reset_level", level, 4'b0101);
        #3 reset_n = 1'b0;
        #1;
        chk("async_reset", {level, rise, fall, toggle, event_flags, event_any}, 0);
        tick(2);
        chk("async_reset_held", {level, rise, fall, toggle, event_flags, event_any}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
